sine_phase_gen: RTL and testbench

//  DDS front end that drives the sine lookup ROM: phase accumulator + sample-rate prescaler.

---
 rtl/sine_phase_gen.sv | 165 ++++++++++++++++
 tb/tb_sine_phase_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_gen.sv
// DDS front end for the sine lookup ROM: phase accumulator, sample-rate prescaler,
// phase-continuous tuning-word update and a valid strobe aligned to the ROM output.
module sine_phase_gen #(
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 7,
    parameter int DIV_W   = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [ACC_W-1:0]  fcw_i,
    input  logic              fcw_load_i,
    output logic              fcw_ack_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              cen_o,
    output logic              wrap_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int DRN_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_fcwActive;
    logic [ACC_W-1:0]    r_fcwPending;
    logic                r_pendFlag;
    logic                r_carrySeen;
    logic [DIV_W-1:0]    r_cnt;
    logic [DRN_W-1:0]    r_drainCnt;
    logic [ROM_LAT-1:0]  r_validSr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cen;
    logic                r_wrap;
    logic                r_ack;
    logic                r_busy;

    logic                w_tick;
    logic [ACC_W:0]      w_sum;
    logic                w_carry;
    logic                w_lastDrain;

    // div_i is compared live, so lowering it below the running count ticks at once
    assign w_tick      = (r_cnt >= div_i);
    assign w_sum       = {1'b0, r_acc} + {1'b0, r_fcwActive};
    assign w_carry     = w_sum[ACC_W];
    assign w_lastDrain = (r_drainCnt == DRN_W'(ROM_LAT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_fcwActive  <= '0;
            r_fcwPending <= '0;
            r_pendFlag   <= 1'b0;
            r_carrySeen  <= 1'b0;
            r_cnt        <= '0;
            r_drainCnt   <= '0;
            r_addr       <= '0;
            r_cen        <= 1'b0;
            r_wrap       <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cen  <= 1'b0;
            r_wrap <= 1'b0;
            r_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_pendFlag) begin
                        r_fcwActive <= r_fcwPending;
                        r_pendFlag  <= 1'b0;
                        r_ack       <= 1'b1;
                    end
                    if (en_i) begin
                        r_state     <= RUN;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_carrySeen <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        r_state    <= DRAIN;
                        r_drainCnt <= '0;
                    end else if (w_tick) begin
                        // Present the pre-add phase; a carry marks the next sample as a wrap
                        r_cnt       <= '0;
                        r_cen       <= 1'b1;
                        r_addr      <= r_acc[ACC_W-1 -: ADDR_W];
                        r_wrap      <= r_carrySeen;
                        r_carrySeen <= w_carry;
                        r_acc       <= w_sum[ACC_W-1:0];
                        if (w_carry && r_pendFlag) begin
                            r_fcwActive <= r_fcwPending;
                            r_pendFlag  <= 1'b0;
                            r_ack       <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_pendFlag) begin
                        r_fcwActive <= r_fcwPending;
                        r_pendFlag  <= 1'b0;
                        r_ack       <= 1'b1;
                    end
                    if (w_lastDrain) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drainCnt <= r_drainCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A load landing on an applying edge becomes the next pending word
            if (fcw_load_i) begin
                r_fcwPending <= fcw_i;
                r_pendFlag   <= 1'b1;
            end
        end
    end

    generate
        if (ROM_LAT == 1) begin : g_validOne
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_validSr <= '0;
                end else begin
                    r_validSr <= r_cen;
                end
            end
        end else begin : g_validMulti
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_validSr <= '0;
                end else begin
                    r_validSr <= {r_validSr[ROM_LAT-2:0], r_cen};
                end
            end
        end
    endgenerate

    assign fcw_ack_o = r_ack;
    assign addr_o    = r_addr;
    assign cen_o     = r_cen;
    assign wrap_o    = r_wrap;
    assign valid_o   = r_validSr[ROM_LAT-1];
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_sine_phase_gen.sv
// Directed bench for sine_phase_gen: expected ROM addresses/wraps are queued as
// stimulus is driven and popped whenever the DUT raises cen_o.
module tb_sine_phase_gen;

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b0;
    logic        en_i       = 1'b0;
    logic [15:0] div_i      = '0;
    logic [15:0] fcw_i      = '0;
    logic        fcw_load_i = 1'b0;
    logic        fcw_ack_o;
    logic [6:0]  addr_o;
    logic        cen_o;
    logic        wrap_o;
    logic        valid_o;
    logic        busy_o;

    typedef struct packed {
        logic [6:0] addr;
        logic       wrap;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   errors   = 0;
    logic lastCen  = 1'b0;
    bit   validChk = 1'b0;

    sine_phase_gen dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .div_i      (div_i),
        .fcw_i      (fcw_i),
        .fcw_load_i (fcw_load_i),
        .fcw_ack_o  (fcw_ack_o),
        .addr_o     (addr_o),
        .cen_o      (cen_o),
        .wrap_o     (wrap_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] div,
                                 input logic [15:0] fcw, input logic load);
        en_i       = en;
        div_i      = div;
        fcw_i      = fcw;
        fcw_load_i = load;
    endtask

    task automatic pushExp(input int addr, input logic wrap);
        exp_t e;
        e.addr = 7'(addr);
        e.wrap = wrap;
        expQ.push_back(e);
    endtask

    // One clock; sample 1 time unit after the edge and score any ROM access
    task automatic stepCycle();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (cen_o === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_cen", 32'(cen_o), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("addr", 32'(addr_o), 32'(e.addr));
                checkOutput("wrap", 32'(wrap_o), 32'(e.wrap));
            end
        end
        if (validChk) checkOutput("valid_delay", 32'(valid_o), 32'(lastCen));
        lastCen = cen_o;
    endtask

    task automatic waitCen(input int gap);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            stepCycle();
            n++;
            if (cen_o === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("cen_timeout", 32'(cen_o), 32'd1);
        else       checkOutput("cen_gap", 32'(n), 32'(gap));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        #12;
        checkOutput("rst_addr",  32'(addr_o),    32'd0);
        checkOutput("rst_cen",   32'(cen_o),     32'd0);
        checkOutput("rst_wrap",  32'(wrap_o),    32'd0);
        checkOutput("rst_valid", 32'(valid_o),   32'd0);
        checkOutput("rst_ack",   32'(fcw_ack_o), 32'd0);
        checkOutput("rst_busy",  32'(busy_o),    32'd0);
        #5 rst_ni = 1'b1;
        validChk = 1'b1;

        // T1: div=0, step 1, full period and wrap
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b1);
        stepCycle();
        checkOutput("t1_ack_early", 32'(fcw_ack_o), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        checkOutput("t1_ack", 32'(fcw_ack_o), 32'd1);
        stepCycle();
        checkOutput("t1_ack_pulse", 32'(fcw_ack_o), 32'd0);
        for (int i = 0; i < 128; i++) pushExp(i, 1'b0);
        pushExp(0, 1'b1);
        pushExp(1, 1'b0);
        applyStimulus(1'b1, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        checkOutput("t1_busy", 32'(busy_o), 32'd1);
        checkOutput("t1_no_cen_on_entry", 32'(cen_o), 32'd0);
        for (int i = 0; i < 130; i++) waitCen(1);
        checkOutput("t1_queue_empty", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("t1_idle", 32'(busy_o), 32'd0);

        // T2: prescaler period 4, then div lowered below the count
        applyStimulus(1'b0, 16'd0, 16'h0400, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 16'd0, 16'h0400, 1'b0);
        stepCycle();
        checkOutput("t2_ack", 32'(fcw_ack_o), 32'd1);
        pushExp(0, 1'b0);
        pushExp(2, 1'b0);
        pushExp(4, 1'b0);
        pushExp(6, 1'b0);
        applyStimulus(1'b1, 16'd3, 16'h0400, 1'b0);
        waitCen(5);
        waitCen(4);
        waitCen(4);
        waitCen(4);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 16'd1, 16'h0400, 1'b0);
        pushExp(8, 1'b0);
        pushExp(10, 1'b0);
        pushExp(12, 1'b0);
        waitCen(1);
        waitCen(2);
        waitCen(2);
        applyStimulus(1'b0, 16'd0, 16'h0400, 1'b0);
        stepCycle();
        stepCycle();

        // T3: pending word overwritten mid-period, applied on the carry tick
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        checkOutput("t3_ack_idle", 32'(fcw_ack_o), 32'd1);
        for (int i = 0; i < 128; i++) pushExp(i, 1'b0);
        pushExp(0, 1'b1);
        pushExp(4, 1'b0);
        pushExp(8, 1'b0);
        pushExp(12, 1'b0);
        applyStimulus(1'b1, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        for (int i = 0; i < 132; i++) begin
            waitCen(1);
            checkOutput("t3_ack", 32'(fcw_ack_o), (i == 127) ? 32'd1 : 32'd0);
            if (i == 40) applyStimulus(1'b1, 16'd0, 16'h1000, 1'b1);
            if (i == 41) applyStimulus(1'b1, 16'd0, 16'h1000, 1'b0);
            if (i == 50) applyStimulus(1'b1, 16'd0, 16'h0800, 1'b1);
            if (i == 51) applyStimulus(1'b1, 16'd0, 16'h0800, 1'b0);
        end

        // T4: stop right after a tick, en during DRAIN ignored, restart at 0
        applyStimulus(1'b0, 16'd0, 16'h0800, 1'b0);
        stepCycle();
        checkOutput("t4_valid_last", 32'(valid_o), 32'd1);
        checkOutput("t4_no_cen", 32'(cen_o), 32'd0);
        checkOutput("t4_busy_drain", 32'(busy_o), 32'd1);
        applyStimulus(1'b1, 16'd0, 16'h0800, 1'b0);
        stepCycle();
        checkOutput("t4_busy_fall", 32'(busy_o), 32'd0);
        checkOutput("t4_no_cen_idle", 32'(cen_o), 32'd0);
        pushExp(0, 1'b0);
        pushExp(4, 1'b0);
        stepCycle();
        checkOutput("t4_busy_rerun", 32'(busy_o), 32'd1);
        checkOutput("t4_no_cen_entry", 32'(cen_o), 32'd0);
        waitCen(1);
        waitCen(1);

        // T5: asynchronous reset mid-run with a word pending
        pushExp(8, 1'b0);
        applyStimulus(1'b1, 16'd0, 16'h0400, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 16'd0, 16'h0400, 1'b0);
        #3 rst_ni = 1'b0;
        #1;
        checkOutput("t5_addr",  32'(addr_o),    32'd0);
        checkOutput("t5_cen",   32'(cen_o),     32'd0);
        checkOutput("t5_wrap",  32'(wrap_o),    32'd0);
        checkOutput("t5_valid", 32'(valid_o),   32'd0);
        checkOutput("t5_ack",   32'(fcw_ack_o), 32'd0);
        checkOutput("t5_busy",  32'(busy_o),    32'd0);
        expQ.delete();
        lastCen = 1'b0;
        #2 rst_ni = 1'b1;

        // T6: active word is 0 after reset, so the phase is frozen at 0
        for (int i = 0; i < 5; i++) pushExp(0, 1'b0);
        stepCycle();
        checkOutput("t6_busy", 32'(busy_o), 32'd1);
        checkOutput("t6_no_cen_entry", 32'(cen_o), 32'd0);
        checkOutput("t6_pending_lost", 32'(fcw_ack_o), 32'd0);
        for (int i = 0; i < 5; i++) waitCen(1);
        for (int i = 0; i < 4; i++) pushExp(0, 1'b0);
        applyStimulus(1'b1, 16'd0, 16'h0200, 1'b1);
        waitCen(1);
        applyStimulus(1'b1, 16'd0, 16'h0200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            waitCen(1);
            checkOutput("t6_ack_held", 32'(fcw_ack_o), 32'd0);
        end
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        checkOutput("t6_ack_run_exit", 32'(fcw_ack_o), 32'd0);
        checkOutput("t6_busy_drain", 32'(busy_o), 32'd1);
        stepCycle();
        checkOutput("t6_ack_drain", 32'(fcw_ack_o), 32'd1);
        checkOutput("t6_busy_idle", 32'(busy_o), 32'd0);
        stepCycle();
        checkOutput("t6_ack_pulse", 32'(fcw_ack_o), 32'd0);
        pushExp(0, 1'b0);
        pushExp(1, 1'b0);
        pushExp(2, 1'b0);
        applyStimulus(1'b1, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        waitCen(1);
        waitCen(1);
        waitCen(1);
        applyStimulus(1'b0, 16'd0, 16'h0200, 1'b0);
        stepCycle();
        stepCycle();

        checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
